lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit between the RV32I execute stage and the word-addressed data memory.
//  Accepts one byte/half/word access per handshake and checks alignment.
//  Drives the memory's single-cycle ld/str strobes with word address, lane-shifted data
//  and byte enables; sign/zero-extends returned load data.
//  Returns a one-cycle response pulse to the core.
// PARAMETERS
//  MEM_AW  12  data-memory word-address width; memory depth 2**MEM_AW words
//  XLEN    32  core data/address width
// PORTS
//  clk              in   1       single clock, all state on posedge
//  rst_n            in   1       asynchronous active-low reset
//  req_valid        in   1       core presents an access
//  req_ready        out  1       LSU can accept; high only in IDLE
//  req_we           in   1       1 = store, 0 = load
//  req_funct3       in   3       RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr         in   XLEN    byte address
//  req_wdata        in   XLEN    store data, right-justified
//  resp_valid       out  1       one-cycle completion pulse
//  resp_err         out  1       with resp_valid: misaligned or illegal funct3
//  resp_rdata       out  XLEN    extended load data, qualified by resp_valid
//  mem_addr         out  MEM_AW  word address = req_addr[MEM_AW+1:2]
//  mem_ld           out  1       read strobe; data on mem_rdata after the next posedge
//  mem_str          out  1       write strobe
//  mem_be           out  4       byte-lane enables for the store
//  mem_wdata        out  XLEN    lane-replicated store data
//  mem_rdata        in   XLEN    registered read data from memory
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; all other outputs 0.
//  - Applies immediately when rst_n falls; an in-flight access is dropped.
//  - No strobe or response is issued after reset asserts.
//  FSM: IDLE, ACCESS, WAIT_RD, RESP, ERR.
//  IDLE: req_ready=1. On req_valid, capture funct3, we, addr[1:0], word address and store
//   data into registers.
//   - Next state is ERR if any of: misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0);
//     funct3 in {011,11x}; store with funct3 in {100,101}.
//   - Otherwise next state is ACCESS.
//  ACCESS: one cycle; mem_ld or mem_str=1. mem_addr, mem_be and mem_wdata are registered and stable.
//   - Store: next state RESP. Load: next state WAIT_RD.
//  WAIT_RD: mem_rdata is valid. Extract the lane selected by addr[1:0] and extend it:
//   - B: sign-extend; BU: zero-extend
//   - H/HU: half at addr[1], sign- or zero-extended
//   - W: whole word
//   Result registers into resp_rdata. Next state RESP.
//  RESP: resp_valid=1, resp_err=0; next IDLE. ERR: resp_valid=1, resp_err=1; next IDLE.
//  resp_rdata: 0 on store and error responses. It holds its value between responses.
//  Store lanes:
//   - SB: wdata[7:0] replicated to all 4 lanes, be=4'b0001<<addr[1:0]
//   - SH: wdata[15:0] replicated to both halves, be=4'b0011<<addr[1:0]
//   - SW: be=4'b1111
//  mem_be=0 during loads. Strobes and mem_be are 0 in every state except ACCESS.
//  Latency after accept edge: store resp 2 cycles; load resp 3; error resp 1.
//  - No back-pressure on the response; the core must take the pulse.
//  - Throughput: one access per 3 (store) or 4 (load) cycles.
//  - req_valid outside IDLE is ignored; the core holds the request until req_ready.
//  Address bits above MEM_AW+1 are ignored, so addresses wrap modulo 4*2**MEM_AW.
//   - Last word 2**MEM_AW-1 is legal; the next word aliases to word 0.
// STRUCTURE
//  lsu_pkg: typedef enum logic [2:0] lsu_state_t {IDLE, ACCESS, WAIT_RD, RESP, ERR};
//   - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU
//   - functions misaligned(), store_be(), store_lanes()
//  Sub-module lsu_load_align: combinational lane extract + sign/zero extend.
//   - Ports: rdata, off[1:0], funct3 -> ext_data. Instantiated once, feeds WAIT_RD capture.
// TESTING
//  1 SW 0xDEADBEEF @0x10 -> ACCESS: mem_addr=4, be=1111, wdata=DEADBEEF;
//    resp_valid 2 cycles after accept, err=0.
//  2 SB 0x000000A5 @0x13 -> be=1000, wdata=A5A5A5A5;
//    then LB @0x13 -> resp_rdata=FFFFFFA5; LBU -> 000000A5.
//  3 LH @0x12 with mem word 0x8001_1234 -> FFFF8001; LHU @0x10 -> 00001234;
//    resp 3 cycles after accept.
//  4 LW @0x06 / SH @0x03 / store funct3=100 -> resp_valid+resp_err next cycle;
//    mem_ld=mem_str=0 throughout.
//  5 rst_n low during ACCESS of a store -> outputs 0 at once, no resp;
//    after release req_ready=1 and a new LW completes normally.
//  6 Back-to-back req_valid held high: loads accepted every 4 cycles.
//    Address 0x4000 with MEM_AW=12 -> mem_addr=0 (wrap).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and store/alignment helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NBE  = XLEN / 8;

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT_RD, RESP, ERR} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access attributes kept for the whole transaction after accept.
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } lsu_req_t;

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Reserved encodings, and unsigned variants that have no store form.
    function automatic logic illegal_op(input logic [2:0] funct3, input logic we);
        return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
    endfunction

    function automatic logic [NBE-1:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B:    return NBE'(4'b0001) << off;
            F3_H:    return NBE'(4'b0011) << off;
            F3_W:    return NBE'(4'b1111);
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] funct3, input logic [XLEN-1:0] wdata);
        case (funct3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and data-memory strobe bundle for the load/store unit.
interface lsu_ctrl_if import lsu_pkg::*; #(
    parameter int unsigned MEM_AW = 12
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [XLEN-1:0]   resp_rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_ld;
    logic              mem_str;
    logic [NBE-1:0]    mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    // Environment side: core plus data memory.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_ld, mem_str, mem_be, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_ld, mem_str, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module lsu_load_align import lsu_pkg::*; (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext_data = {24'h0, byte_sel};
            F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext_data = {16'h0, half_sel};
            default: ext_data = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: one aligned access per handshake to a word-addressed data memory.
module lsu_ctrl import lsu_pkg::*; #(
    parameter int unsigned MEM_AW = 12
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_ctrl_if.slave bus
);
    lsu_state_t      state, state_d;
    lsu_req_t        req_q;
    logic            accept, req_bad, rdata_ld, rdata_clr;
    logic            req_ready_d, resp_valid_d, resp_err_d, mem_ld_d, mem_str_d;
    logic [NBE-1:0]  mem_be_d;
    logic [XLEN-1:0] ext_data;
    logic            unused_addr_hi;

    // Upper address bits alias: memory wraps modulo its byte size.
    assign unused_addr_hi = ^bus.req_addr[XLEN-1:MEM_AW+2];
    assign req_bad = misaligned(bus.req_funct3, bus.req_addr[1:0])
                  || illegal_op(bus.req_funct3, bus.req_we);

    lsu_load_align u_align (
        .rdata    (bus.mem_rdata),
        .off      (req_q.off),
        .funct3   (req_q.funct3),
        .ext_data (ext_data)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        rdata_ld  = 1'b0;
        rdata_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_bad) begin
                        state_d   = ERR;
                        rdata_clr = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d   = req_q.we ? RESP : WAIT_RD;
                rdata_clr = req_q.we;
            end
            WAIT_RD: begin
                state_d  = RESP;
                rdata_ld = 1'b1;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP) || (state_d == ERR);
        resp_err_d   = (state_d == ERR);
        mem_ld_d     = accept && !req_bad && !bus.req_we;
        mem_str_d    = accept && !req_bad && bus.req_we;
        mem_be_d     = mem_str_d ? store_be(bus.req_funct3, bus.req_addr[1:0]) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_q          <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_addr   <= '0;
            bus.mem_ld     <= 1'b0;
            bus.mem_str    <= 1'b0;
            bus.mem_be     <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            state          <= state_d;
            bus.req_ready  <= req_ready_d;
            bus.resp_valid <= resp_valid_d;
            bus.resp_err   <= resp_err_d;
            bus.mem_ld     <= mem_ld_d;
            bus.mem_str    <= mem_str_d;
            bus.mem_be     <= mem_be_d;
            if (accept) begin
                req_q         <= '{we: bus.req_we, funct3: bus.req_funct3, off: bus.req_addr[1:0]};
                bus.mem_addr  <= bus.req_addr[MEM_AW+1:2];
                bus.mem_wdata <= bus.req_we ? store_lanes(bus.req_funct3, bus.req_wdata) : '0;
            end
            if (rdata_ld) begin
                bus.resp_rdata <= ext_data;
            end else if (rdata_clr) begin
                bus.resp_rdata <= '0;
            end
        end
    end
endmodule
